// File: rtl/cache_pkg.sv
// Shared types and constants for the 2-way, 64-set cache fill controller.
// Metadata byte layout: [7:2] tag, [1] lru, [0] valid.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    TAG  = 2'd3
  } state_e;

  localparam int ADDR_W          = 16;
  localparam int TAG_W           = 6;
  localparam int SET_W           = 6;
  localparam int WORD_W          = 3;
  localparam int NUM_SETS        = 64;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int MEM_LATENCY     = 4;

  localparam int TAG_MSB   = 7;
  localparam int TAG_LSB   = 2;
  localparam int LRU_BIT   = 1;
  localparam int VALID_BIT = 0;

  function automatic logic [WORDS_PER_BLOCK-1:0] word_onehot(input logic [WORD_W-1:0] w);
    return WORDS_PER_BLOCK'(1) << w;
  endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Bus bundle between the fill controller and its surroundings:
// pipeline lookup (req_valid/req_addr, hit/hit_way/stall), metadata array
// (meta_out0/1, meta_write0/1, meta_din), data array (data_write0/1,
// word_enable, data_din), shared set select (block_enable) and main memory
// (mem_en/mem_addr, mem_data_valid/mem_data).
// master: controller view. slave: pipeline/array/memory view.
interface cache_fill_ctrl_if
  import cache_pkg::*;
;
  logic                       req_valid;
  logic [ADDR_W-1:0]          req_addr;
  logic [7:0]                 meta_out0;
  logic [7:0]                 meta_out1;
  logic                       hit;
  logic                       hit_way;
  logic                       stall;
  logic [NUM_SETS-1:0]        block_enable;
  logic                       meta_write0;
  logic                       meta_write1;
  logic [7:0]                 meta_din;
  logic                       data_write0;
  logic                       data_write1;
  logic [WORDS_PER_BLOCK-1:0] word_enable;
  logic [15:0]                data_din;
  logic                       mem_en;
  logic [ADDR_W-1:0]          mem_addr;
  logic                       mem_data_valid;
  logic [15:0]                mem_data;

  modport master (
    input  req_valid, req_addr, meta_out0, meta_out1, mem_data_valid, mem_data,
    output hit, hit_way, stall, block_enable, meta_write0, meta_write1, meta_din,
           data_write0, data_write1, word_enable, data_din, mem_en, mem_addr
  );

  modport slave (
    output req_valid, req_addr, meta_out0, meta_out1, mem_data_valid, mem_data,
    input  hit, hit_way, stall, block_enable, meta_write0, meta_write1, meta_din,
           data_write0, data_write1, word_enable, data_din, mem_en, mem_addr
  );
endinterface

// File: rtl/cache_fill_ctrl_set_decoder.sv
// set_decoder: 6-bit set index to 64-bit one-hot array row select.
// Ports: set_idx (in, 6), set_onehot (out, 64).
module set_decoder
  import cache_pkg::*;
(
  input  logic [SET_W-1:0]    set_idx,
  output logic [NUM_SETS-1:0] set_onehot
);
  assign set_onehot = NUM_SETS'(1) << set_idx;
endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: lookup / miss handler for a 2-way, 64-set cache.
// Flags hit/miss from both ways' metadata, refreshes LRU on hit, and on miss
// picks a victim, streams 8 word reads from memory into the data array and
// finally writes {tag,lru=1,valid=1} for the victim way.
// Ports: clk, rst (async active-low), bus (cache_fill_ctrl_if.master).
// Optional macro CACHE_PERF_CNT_EN adds saturating hit_cnt/miss_cnt outputs.
//
// state | meaning
// IDLE  | lookup; hit refreshes LRU, miss latches tag/set/victim
// REQ   | issue 8 consecutive memory reads (words 0..7)
// WAIT  | drain remaining returned words into the data array
// TAG   | write victim metadata, then back to IDLE for the retry
module cache_fill_ctrl
  import cache_pkg::*;
(
  input logic               clk,
  input logic               rst,
  cache_fill_ctrl_if.master bus
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    req_tag, tag_q, tag_d;
  logic [SET_W-1:0]    req_set, set_q, set_d, set_sel;
  logic                victim_q, victim_d;
  logic [WORD_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [WORD_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic [WORD_W:0]     rcv_cnt_q, rcv_cnt_d;
  logic                wr_pend_q, wr_pend_d;
  logic [15:0]         data_din_q, data_din_d;
  logic                idle, fill_active;
  logic                way0_match, way1_match, any_match;
  logic                lookup_hit, miss_start, victim_way;
  logic                accept, last_write;
  logic [NUM_SETS-1:0] block_enable_w;
  logic [3:0]          unused_addr_bits;

  assign req_tag          = bus.req_addr[15:10];
  assign req_set          = bus.req_addr[9:4];
  assign unused_addr_bits = bus.req_addr[3:0];

  assign idle        = (state_q == IDLE);
  assign fill_active = (state_q == REQ) || (state_q == WAIT);

  assign way0_match = bus.meta_out0[VALID_BIT] && (bus.meta_out0[TAG_MSB:TAG_LSB] == req_tag);
  assign way1_match = bus.meta_out1[VALID_BIT] && (bus.meta_out1[TAG_MSB:TAG_LSB] == req_tag);
  assign any_match  = way0_match || way1_match;
  assign lookup_hit = bus.req_valid && idle && any_match;
  assign miss_start = bus.req_valid && idle && !any_match;

  // Invalid way first (way0 before way1); otherwise the way whose lru bit is
  // set, with equal lru bits falling back to way0.
  always_comb begin
    victim_way = 1'b0;
    if (!bus.meta_out0[VALID_BIT])      victim_way = 1'b0;
    else if (!bus.meta_out1[VALID_BIT]) victim_way = 1'b1;
    else victim_way = bus.meta_out1[LRU_BIT] && !bus.meta_out0[LRU_BIT];
  end

  // Words beyond the eighth in a fill are dropped.
  assign accept     = fill_active && bus.mem_data_valid && (rcv_cnt_q < (WORD_W+1)'(WORDS_PER_BLOCK));
  assign last_write = wr_pend_q && (rx_cnt_q == WORD_W'(WORDS_PER_BLOCK-1));

  assign set_sel = idle ? req_set : set_q;

  set_decoder u_set_decoder (
    .set_idx    (set_sel),
    .set_onehot (block_enable_w)
  );
  assign bus.block_enable = block_enable_w;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (miss_start) state_d = REQ;
      REQ:  if (issue_cnt_q == WORD_W'(WORDS_PER_BLOCK-1)) state_d = WAIT;
      WAIT: if (last_write) state_d = TAG;
      TAG:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.hit         = lookup_hit;
    bus.hit_way     = lookup_hit && !way0_match;
    bus.stall       = !idle || miss_start;
    bus.meta_write0 = 1'b0;
    bus.meta_write1 = 1'b0;
    bus.meta_din    = 8'h00;
    bus.data_write0 = wr_pend_q && !victim_q;
    bus.data_write1 = wr_pend_q && victim_q;
    bus.word_enable = wr_pend_q ? word_onehot(rx_cnt_q) : '0;
    bus.data_din    = data_din_q;
    bus.mem_en      = 1'b0;
    bus.mem_addr    = {tag_q, set_q, issue_cnt_q, 1'b0};
    case (state_q)
      IDLE: begin
        bus.meta_write0 = lookup_hit && way0_match;
        bus.meta_write1 = lookup_hit && !way0_match;
        bus.meta_din    = {req_tag, 2'b11};
      end
      REQ: bus.mem_en = 1'b1;
      TAG: begin
        bus.meta_write0 = !victim_q;
        bus.meta_write1 = victim_q;
        bus.meta_din    = {tag_q, 2'b11};
      end
      default: ;
    endcase
  end

  // Fill datapath
  always_comb begin
    tag_d       = tag_q;
    set_d       = set_q;
    victim_d    = victim_q;
    issue_cnt_d = issue_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    rcv_cnt_d   = rcv_cnt_q;
    data_din_d  = data_din_q;
    wr_pend_d   = accept;
    if (miss_start) begin
      tag_d       = req_tag;
      set_d       = req_set;
      victim_d    = victim_way;
      issue_cnt_d = '0;
      rx_cnt_d    = '0;
      rcv_cnt_d   = '0;
    end
    if (state_q == REQ) issue_cnt_d = issue_cnt_q + WORD_W'(1);
    if (accept) begin
      rcv_cnt_d  = rcv_cnt_q + (WORD_W+1)'(1);
      data_din_d = bus.mem_data;
    end
    if (wr_pend_q) rx_cnt_d = rx_cnt_q + WORD_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q       <= '0;
      set_q       <= '0;
      victim_q    <= 1'b0;
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
      rcv_cnt_q   <= '0;
      wr_pend_q   <= 1'b0;
      data_din_q  <= '0;
    end else begin
      tag_q       <= tag_d;
      set_q       <= set_d;
      victim_q    <= victim_d;
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
      wr_pend_q   <= wr_pend_d;
      data_din_q  <= data_din_d;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (lookup_hit && (hit_cnt_q != 16'hFFFF))  hit_cnt_d  = hit_cnt_q + 16'd1;
    if (miss_start && (miss_cnt_q != 16'hFFFF)) miss_cnt_d = miss_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
module tb_cache_fill_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  cache_fill_ctrl_if bus ();

`ifdef CACHE_PERF_CNT_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  cache_fill_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  // ---------------- environment: metadata/data arrays ----------------
  logic [7:0]  env_meta [2][64];
  logic [15:0] env_data [2][64][8];
  logic [5:0]  be_idx;
  logic [2:0]  we_idx;
  logic        pl_en = 1'b0;
  logic        pl_way = 1'b0;
  logic [5:0]  pl_set = '0;
  logic [7:0]  pl_val = '0;

  always_comb begin
    be_idx = '0;
    for (int i = 0; i < 64; i++) if (bus.block_enable[i]) be_idx = 6'(i);
    we_idx = '0;
    for (int i = 0; i < 8; i++) if (bus.word_enable[i]) we_idx = 3'(i);
  end

  assign bus.meta_out0 = env_meta[0][be_idx];
  assign bus.meta_out1 = env_meta[1][be_idx];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < 64; s++) env_meta[w][s] <= 8'h00;
    end else begin
      if (pl_en) env_meta[pl_way][pl_set] <= pl_val;
      if (bus.meta_write0) env_meta[0][be_idx] <= bus.meta_din;
      if (bus.meta_write1) env_meta[1][be_idx] <= bus.meta_din;
      if (bus.data_write0) env_data[0][be_idx][we_idx] <= bus.data_din;
      if (bus.data_write1) env_data[1][be_idx][we_idx] <= bus.data_din;
    end
  end

  // ---------------- environment: main memory ----------------
  logic [15:0] mq_addr[$];
  int          mq_due[$];
  int          cyc;
  bit          gap_en = 1'b0;
  logic [15:0] salt = 16'h5A3C;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ salt;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq_addr.delete();
      mq_due.delete();
      cyc                <= 0;
      bus.mem_data_valid <= 1'b0;
      bus.mem_data       <= 16'h0000;
    end else begin
      cyc <= cyc + 1;
      if (mq_addr.size() > 0 && mq_due[0] <= cyc + 1 && !(gap_en && $urandom_range(1, 0) == 1)) begin
        bus.mem_data_valid <= 1'b1;
        bus.mem_data       <= mem_word(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        bus.mem_data_valid <= 1'b0;
        bus.mem_data       <= 16'($urandom);
      end
      if (bus.mem_en) begin
        mq_addr.push_back(bus.mem_addr);
        mq_due.push_back(cyc + 4);
      end
    end
  end

  // ---------------- reference cache state ----------------
  bit         ref_v [2][64];
  logic [5:0] ref_t [2][64];
  bit         ref_l [2][64];

  task automatic clear_ref();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 64; s++) begin
        ref_v[w][s] = 1'b0;
        ref_l[w][s] = 1'b0;
        ref_t[w][s] = '0;
      end
  endtask

  task automatic do_reset();
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    rst = 1'b0;
    clear_ref();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic preload(input bit way, input logic [5:0] s, input logic [5:0] t, input bit lru);
    @(negedge clk);
    pl_en = 1'b1; pl_way = way; pl_set = s; pl_val = {t, lru, 1'b1};
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_v[way][s] = 1'b1; ref_t[way][s] = t; ref_l[way][s] = lru;
  endtask

  // One lookup; on a miss follows the fill through to the retry hit.
  task automatic run_access(input logic [15:0] addr, input bit chk_penalty);
    logic [5:0] t, s;
    bit h0, h1, eh, ew, ev;
    int nw, nmeta, nbad, ncyc, k, dbad;
    t = addr[15:10];
    s = addr[9:4];
    h0 = ref_v[0][s] && ref_t[0][s] == t;
    h1 = ref_v[1][s] && ref_t[1][s] == t;
    eh = h0 || h1;
    ew = !h0 && h1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    #1;
    total++; if (bus.hit !== eh) begin bad++; $display("FAIL hit addr=%h got=%b want=%b", addr, bus.hit, eh); end
    total++; if (bus.hit_way !== (eh && ew)) begin bad++; $display("FAIL hit_way addr=%h got=%b want=%b", addr, bus.hit_way, eh && ew); end
    total++; if (bus.stall !== !eh) begin bad++; $display("FAIL stall_idle addr=%h got=%b want=%b", addr, bus.stall, !eh); end
    total++; if (bus.block_enable !== (64'd1 << s)) begin bad++; $display("FAIL block_enable addr=%h got=%h want=%h", addr, bus.block_enable, 64'd1 << s); end
    total++; if ({bus.meta_write1, bus.meta_write0} !== (eh ? (ew ? 2'b10 : 2'b01) : 2'b00)) begin
      bad++; $display("FAIL lookup_meta_write addr=%h got=%b%b hit=%b way=%b", addr, bus.meta_write1, bus.meta_write0, eh, ew);
    end
    if (eh) begin
      total++; if (bus.meta_din !== {t, 2'b11}) begin bad++; $display("FAIL hit_meta_din got=%h want=%h", bus.meta_din, {t, 2'b11}); end
      ref_l[ew][s] = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      return;
    end
    ev = !ref_v[0][s] ? 1'b0 : (!ref_v[1][s] ? 1'b1 : (ref_l[1][s] && !ref_l[0][s]));
    ncyc = 1; nw = 0; nmeta = 0; nbad = 0; k = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #1;
      if (!bus.stall) break;
      ncyc++;
      if (bus.mem_en) begin
        if (bus.mem_addr !== {t, s, 3'(k), 1'b0}) nbad++;
        k++;
      end
      if (ev ? bus.data_write1 : bus.data_write0) begin
        if (bus.word_enable !== 8'(1 << nw)) nbad++;
        if (bus.data_din !== mem_word({t, s, 3'(nw), 1'b0})) nbad++;
        nw++;
      end
      if (ev ? bus.data_write0 : bus.data_write1) nbad++;
      if (bus.meta_write0 || bus.meta_write1) begin
        nmeta++;
        if ((ev ? bus.meta_write0 : bus.meta_write1) || bus.meta_din !== {t, 2'b11}) nbad++;
      end
    end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL fill_timeout addr=%h stall=%b after %0d cycles", addr, bus.stall, ncyc); end
    total++; if (nbad != 0) begin bad++; $display("FAIL fill_sequence addr=%h errors=%0d want=0", addr, nbad); end
    total++; if (k != 8) begin bad++; $display("FAIL mem_requests addr=%h got=%0d want=8", addr, k); end
    total++; if (nw != 8) begin bad++; $display("FAIL data_writes addr=%h got=%0d want=8", addr, nw); end
    total++; if (nmeta != 1) begin bad++; $display("FAIL fill_meta_writes addr=%h got=%0d want=1", addr, nmeta); end
    if (chk_penalty) begin
      total++; if (ncyc != 15) begin bad++; $display("FAIL miss_penalty addr=%h got=%0d want=15", addr, ncyc); end
    end
    total++; if (bus.hit !== 1'b1 || bus.hit_way !== ev) begin
      bad++; $display("FAIL retry_hit addr=%h hit=%b way=%b want hit=1 way=%b", addr, bus.hit, bus.hit_way, ev);
    end
    total++; if (env_meta[ev][s] !== {t, 2'b11}) begin bad++; $display("FAIL meta_array addr=%h got=%h want=%h", addr, env_meta[ev][s], {t, 2'b11}); end
    dbad = 0;
    for (int w = 0; w < 8; w++) if (env_data[ev][s][w] !== mem_word({t, s, 3'(w), 1'b0})) dbad++;
    total++; if (dbad != 0) begin bad++; $display("FAIL data_array addr=%h wrong_words=%0d want=0", addr, dbad); end
    ref_v[ev][s] = 1'b1; ref_t[ev][s] = t; ref_l[ev][s] = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", bus.stall); end
    total++; if (bus.mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en got=%b want=0", bus.mem_en); end
    total++; if ({bus.meta_write0, bus.meta_write1, bus.data_write0, bus.data_write1} !== 4'b0) begin
      bad++; $display("FAIL reset_strobes got=%b want=0000", {bus.meta_write0, bus.meta_write1, bus.data_write0, bus.data_write1});
    end
    total++; if (bus.data_din !== 16'h0000) begin bad++; $display("FAIL reset_data_din got=%h want=0000", bus.data_din); end
    total++; if (bus.hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b want=0", bus.hit); end
  endtask

  task automatic test_first_miss();
    run_access(16'h1234, 1'b1);
  endtask

  task automatic test_hit();
    run_access(16'h1234, 1'b0);
    run_access(16'h123A, 1'b0);
  endtask

  task automatic test_victim_lru();
    preload(1'b0, 6'h10, 6'h01, 1'b0);
    preload(1'b1, 6'h10, 6'h02, 1'b1);
    run_access(16'h0D00, 1'b1);
    run_access(16'h0400, 1'b0);
  endtask

  task automatic test_random_gaps();
    gap_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      salt = 16'($urandom);
      run_access({6'($urandom_range(3, 0)), 6'($urandom_range(2, 0) + 6'h30), 4'($urandom)}, 1'b0);
    end
    gap_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++)
      run_access({6'($urandom_range(5, 0)), 6'h20 + 6'($urandom_range(1, 0)), 4'($urandom)}, 1'b1);
  endtask

  task automatic test_reset_mid_fill();
    int nw, nmeta;
    nw = 0; nmeta = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h5BF0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); #1;
      if (bus.data_write0 || bus.data_write1) nw++;
      if (nw >= 3 && !bus.mem_en) break;
    end
    bus.req_valid = 1'b0;
    rst = 1'b0;
    clear_ref();
    #1;
    total++; if (nw < 3) begin bad++; $display("FAIL midfill_progress writes=%0d want>=3", nw); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL midfill_stall got=%b want=0", bus.stall); end
    total++; if (bus.mem_en !== 1'b0 || bus.data_write0 !== 1'b0 || bus.data_write1 !== 1'b0) begin
      bad++; $display("FAIL midfill_strobes mem_en=%b dw=%b%b want 0", bus.mem_en, bus.data_write1, bus.data_write0);
    end
    for (int c = 0; c < 3; c++) begin
      if (bus.meta_write0 || bus.meta_write1) nmeta++;
      @(negedge clk); #1;
    end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (bus.meta_write0 || bus.meta_write1 || bus.stall) nmeta++;
      @(negedge clk); #1;
    end
    total++; if (nmeta != 0) begin bad++; $display("FAIL midfill_meta_write got=%0d want=0", nmeta); end
    run_access(16'h5BF0, 1'b1);
  endtask

`ifdef CACHE_PERF_CNT_EN
  task automatic test_perf_cnt();
    do_reset();
    run_access(16'h1234, 1'b1);
    run_access(16'h1234, 1'b0);
    run_access(16'h1236, 1'b0);
    total++; if (hit_cnt !== 16'd3) begin bad++; $display("FAIL hit_cnt got=%0d want=3", hit_cnt); end
    total++; if (miss_cnt !== 16'd1) begin bad++; $display("FAIL miss_cnt got=%0d want=1", miss_cnt); end
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h1234;
    repeat (65540) @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    total++; if (hit_cnt !== 16'hFFFF) begin bad++; $display("FAIL hit_cnt_sat got=%h want=ffff", hit_cnt); end
    total++; if (miss_cnt !== 16'd1) begin bad++; $display("FAIL miss_cnt_hold got=%0d want=1", miss_cnt); end
  endtask
`endif

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    test_reset();
    test_first_miss();
    test_hit();
    test_victim_lru();
    test_random_gaps();
    test_back_to_back();
    test_reset_mid_fill();
`ifdef CACHE_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
